// File: rtl/add_sub_pipe_pkg.sv
// Shared constants and helpers for the chunked pipelined adder/subtractor.
package add_sub_pipe_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_STAGES = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef struct packed {
    logic c;
    logic ovf;
  } flags_t;

  function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  // Subtraction is a + ~b + 1, so the incoming carry is forced in SUB mode.
  function automatic logic carry_in0(input logic sub, input logic cin);
    return (mode_e'(sub) == MODE_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/add_sub_pipe_if.sv
// Operand/result handshake bundle for add_sub_pipe.
interface add_sub_pipe_if
  import add_sub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, c, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, c, ovf
  );
endinterface

// File: rtl/add_sub_pipe_add_chunk.sv
// Ripple full-adder chain for one pipeline chunk; also exposes the carry into its MSB.
module add_chunk #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         cmsb
);
  logic [W:0] cy;

  always_comb begin
    cy    = '0;
    s     = '0;
    cy[0] = ci;
    for (int i = 0; i < int'(W); i++) begin
      s[i]    = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end
  end

  assign co   = cy[W];
  assign cmsb = cy[W-1];
endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/sub: one CHUNK-bit slice per stage, operands and partial sums ride along.
module add_sub_pipe
  import add_sub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic          clk,
  input  logic          rst_n,
  add_sub_pipe_if.slave bus
);
  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  logic             v_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  flags_t           fl_q  [STAGES];

  logic             op_v   [STAGES];
  logic [WIDTH-1:0] op_a   [STAGES];
  logic [WIDTH-1:0] op_b   [STAGES];
  logic [WIDTH-1:0] op_sum [STAGES];
  logic             op_ci  [STAGES];
  logic [WIDTH-1:0] sum_nx [STAGES];
  logic [CHUNK-1:0] ch_s   [STAGES];
  logic             ch_co  [STAGES];
  logic             ch_cm  [STAGES];

  logic advance;

  // Whole pipe moves together; it only stalls when a result is waiting unclaimed.
  assign advance      = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int unsigned      LSB  = k * CHUNK;
    localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << LSB;

    if (k == 0) begin : g_head
      assign op_v[k]   = bus.in_valid;
      assign op_a[k]   = bus.a;
      assign op_b[k]   = (mode_e'(bus.sub) == MODE_SUB) ? ~bus.b : bus.b;
      assign op_ci[k]  = carry_in0(bus.sub, bus.cin);
      assign op_sum[k] = '0;
    end else begin : g_body
      assign op_v[k]   = v_q[k-1];
      assign op_a[k]   = a_q[k-1];
      assign op_b[k]   = b_q[k-1];
      assign op_ci[k]  = fl_q[k-1].c;
      assign op_sum[k] = sum_q[k-1];
    end

    add_chunk #(.W(CHUNK)) u_add (
      .a    (op_a[k][LSB +: CHUNK]),
      .b    (op_b[k][LSB +: CHUNK]),
      .ci   (op_ci[k]),
      .s    (ch_s[k]),
      .co   (ch_co[k]),
      .cmsb (ch_cm[k])
    );

    assign sum_nx[k] = (op_sum[k] & ~MASK) | (WIDTH'(ch_s[k]) << LSB);
  end

  // Stage registers; overflow is only meaningful out of the last stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        fl_q[k]  <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        v_q[k]   <= op_v[k];
        a_q[k]   <= op_a[k];
        b_q[k]   <= op_b[k];
        sum_q[k] <= sum_nx[k];
        fl_q[k]  <= '{c: ch_co[k], ovf: ch_co[k] ^ ch_cm[k]};
      end
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.s         = sum_q[STAGES-1];
  assign bus.c         = fl_q[STAGES-1].c;
  assign bus.ovf       = fl_q[STAGES-1].ovf;
endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe (WIDTH=16, STAGES=4): vector table, directed corners, random stream.
module tb_add_sub_pipe;
  localparam int unsigned W   = 16;
  localparam int          LAT = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
  } op_t;

  typedef struct {
    op_t op;
    int  acc;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  op_t pend_q[$];
  sb_t sb_q[$];

  add_sub_pipe_if #(.WIDTH(W)) bus ();

  add_sub_pipe #(.WIDTH(W), .STAGES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic plus the sign-rule definition of overflow.
  function automatic op_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub);
    op_t          r;
    logic [W-1:0] beff;
    logic [W:0]   full;
    beff  = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, beff} + (W+1)'(sub ? 1'b1 : cin);
    r.a   = a;
    r.b   = b;
    r.cin = cin;
    r.sub = sub;
    r.s   = full[W-1:0];
    r.c   = full[W];
    r.ovf = (a[W-1] == beff[W-1]) && (r.s[W-1] != a[W-1]);
    return r;
  endfunction

  // rdy_mode: 0 always ready, 1 random, 2 one 3-cycle stall once results appear.
  task automatic run_stream(input int rdy_mode, input bit gaps, input bit check_lat);
    int budget = 5000;
    int stall_left = 0;
    bit stalled_once = 1'b0;
    logic r;
    while ((pend_q.size() > 0 || sb_q.size() > 0) && budget > 0) begin
      @(negedge clk);
      budget--;
      case (rdy_mode)
        0: r = 1'b1;
        1: r = ($urandom_range(3) != 0);
        default: begin
          if (!stalled_once && bus.out_valid) begin
            stall_left   = 3;
            stalled_once = 1'b1;
          end
          r = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      bus.out_ready = r;
      if (pend_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        bus.in_valid = 1'b1;
        bus.a        = pend_q[0].a;
        bus.b        = pend_q[0].b;
        bus.cin      = pend_q[0].cin;
        bus.sub      = pend_q[0].sub;
      end else begin
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
      end
      #1;
      if (rdy_mode == 2 && !r) chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("s", 32'(bus.s), 32'(sb_q[0].op.s));
          chk("c", 32'(bus.c), 32'(sb_q[0].op.c));
          chk("ovf", 32'(bus.ovf), 32'(sb_q[0].op.ovf));
          if (check_lat) chk("latency", 32'(cyc - sb_q[0].acc), 32'(LAT));
          if (r) void'(sb_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back('{op: pend_q[0], acc: cyc});
        void'(pend_q.pop_front());
      end
    end
    bus.in_valid = 1'b0;
    if (budget == 0) chk("stream_timeout", 32'(pend_q.size() + sb_q.size()), 32'd0);
  endtask

  task automatic idle_check(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk(name, 32'(bus.out_valid), 32'd0);
    end
  endtask

  op_t tbl[12];

  initial begin
    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[9]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[10] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[11] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_s", 32'(bus.s), 32'd0);
    chk("rst_c", 32'(bus.c), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Vector table, back-to-back with fixed latency.
    for (int i = 0; i < 12; i++) pend_q.push_back(tbl[i]);
    run_stream(0, 1'b0, 1'b1);
    idle_check(6, "table_no_extra");

    // Ten consecutive operations, always ready.
    for (int i = 0; i < 10; i++)
      pend_q.push_back(model(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom)));
    run_stream(0, 1'b0, 1'b1);
    idle_check(6, "b2b_no_extra");

    // Full pipe held by a 3-cycle downstream stall.
    for (int i = 0; i < 10; i++)
      pend_q.push_back(model(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom)));
    run_stream(2, 1'b0, 1'b0);
    idle_check(6, "stall_no_extra");

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.sub       = 1'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    idle_check(8, "post_rst_out_valid");
    pend_q.push_back(model(16'h1234, 16'h0FFF, 1'b0, 1'b1));
    run_stream(0, 1'b0, 1'b1);
    idle_check(4, "post_rst_no_extra");

    // Random stream with input gaps and random back-pressure.
    for (int i = 0; i < 300; i++)
      pend_q.push_back(model(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom)));
    run_stream(1, 1'b1, 1'b0);
    idle_check(6, "rand_no_extra");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
